sevenseg_display_sched: RTL and testbench
=========================================

// Module: sevenseg_display_sched
// PURPOSE
//   Display scheduler in front of the 4-digit seven-segment mux.
//   Generates the per-digit scan_en tick and owns the mux digit/dp inputs.
//   Arbitrates the display between the live score (default owner) and
//   one-shot event messages (e.g. shot result), each held for a fixed time.
//   Applies leading-zero blanking to the score.
// PARAMETERS
//   CLK_HZ      100_000_000  system clock frequency
//   SCAN_HZ     1000         scan_en rate; DIV = CLK_HZ/SCAN_HZ, DIV >= 2
//   HOLD_TICKS  1500         scan ticks an event stays displayed (>= 1)
//   BLINK_TICKS 250          scan ticks per blink phase (SEVENSEG_BLINK_EN only)
// PORTS
//   clk        in   1   system clock
//   rst        in   1   synchronous reset, active-high
//   score_bcd  in   16  score, 4 BCD digits, [15:12] = d3
//   evt_req    in   1   1-cycle pulse: capture evt_bcd and show it
//   evt_bcd    in   16  event message digits (4'hF = blank digit)
//   evt_busy   out  1   1 while the event owns the display
//   scan_en    out  1   1-cycle pulse every DIV clocks, to the mux
//   d3,d2,d1,d0   out 4 each  digit codes to the mux (4'hF = blank)
//   dp3,dp2,dp1,dp0 out 1 each  decimal points, active-low (1 = off)
// BEHAVIOUR
//   Clocking: one clock (clk); reset is synchronous and active-high (rst).
//   Reset: all state and outputs cleared in the same edge, including mid-event:
//     d* = 4'hF, dp* = 1, scan_en = 0, evt_busy = 0, prescaler = 0,
//     state = SHOW_SCORE.
//   Prescaler: counts 0..DIV-1. scan_en = 1 for exactly the cycle after the
//     count reaches DIV-1, then the count wraps to 0. First pulse is DIV clocks
//     after reset release.
//   SHOW_SCORE (default):
//     Outputs track score_bcd with 1-cycle latency (registered).
//     Blanking: d3 is blank if 0. d2 is blank if d3 and d2 are 0.
//     d1 is blank if d3..d1 are 0. d0 is never blanked (score 0 shows "   0").
//     Digits > 9 pass through unchanged; the mux renders them blank.
//     dp* = 4'b1111.
//   evt_req in any state:
//     Capture evt_bcd, load hold_cnt = HOLD_TICKS-1, and go to SHOW_EVENT
//     on the next edge.
//     A re-request during SHOW_EVENT re-captures and restarts the hold.
//   SHOW_EVENT:
//     d* = captured digits, no blanking. dp0 = 0 (event indicator),
//     dp3..dp1 = 1. evt_busy = 1.
//     hold_cnt decrements on each scan_en.
//     A scan_en with hold_cnt == 0 returns to SHOW_SCORE next edge
//     (evt_busy = 0 and score shown on the same edge).
//   Simultaneous evt_req and expiry: evt_req wins (hold restarts).
//   score_bcd changes during SHOW_EVENT are not shown. The current score
//     appears on return.
// CONFIGURATION
//   SEVENSEG_BLINK_EN defined: in SHOW_EVENT, display phase toggles every
//     BLINK_TICKS scan ticks. Phase is "on" at capture and on re-capture.
//     In the off phase, d* = 4'hF and dp0 = 1. evt_busy and hold are unaffected.
//   Undefined: event shown steadily. The blink counter is not synthesized.
// STRUCTURE
//   Package sevenseg_pkg: BLANK_DIGIT = 4'hF, DP_OFF = 1'b1,
//     state encoding {SHOW_SCORE, SHOW_EVENT}, scan-divider width function.
//   Sub-module scan_prescaler (CLK_HZ, SCAN_HZ -> tick). It is reused later
//     for debounce/animation timing.
//   Rest of the block: state machine, hold/blink counters, blanking logic,
//     output registers.
// TESTING  (sim params: CLK_HZ=1000, SCAN_HZ=100 -> DIV=10, HOLD_TICKS=4, BLINK_TICKS=2)
//   1 Reset release; watch 35 clks -> scan_en pulses at clks 10, 20, 30 after
//     release, each 1 cycle wide. d* = F, F, F, F until the first score sample.
//   2 score_bcd=16'h0042 -> d = F,F,4,2 one cycle later.
//     16'h0000 -> F,F,F,0. 16'h1005 -> 1,0,0,5.
//     16'h00A7 -> F,F,A,7.
//   3 evt_req with evt_bcd=16'h0300 -> next cycle d = 0,3,0,0, dp0=0, evt_busy=1.
//     After 4 scan ticks -> score restored, dp0=1, evt_busy=0.
//   4 Second evt_req (16'h0200) after 2 ticks of an event -> shows 0,2,0,0.
//     Busy lasts 4 more ticks.
//     evt_req on the expiry tick -> stays in SHOW_EVENT.
//   5 rst asserted mid-event -> next edge: evt_busy=0, d*=F, prescaler=0.
//     After release, state is SHOW_SCORE.
//   6 SEVENSEG_BLINK_EN: event shows digits on ticks 0-1, blank on ticks 2-3,
//     then returns to score. Without the macro: steady for all 4 ticks.

Source files
------------

// File: rtl/sevenseg_display_sched_pkg.sv
// Shared constants, display-owner state encoding and counter sizing for the
// seven-segment display scheduler.
package sevenseg_pkg;
  localparam logic [3:0] BLANK_DIGIT = 4'hF;
  localparam logic       DP_OFF      = 1'b1;

  typedef enum logic {
    SHOW_SCORE = 1'b0,
    SHOW_EVENT = 1'b1
  } state_t;

  // Bits needed to hold a down/up counter spanning 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sevenseg_display_sched_if.sv
// Bundle between the display scheduler and its clients: score/event inputs,
// scan tick and digit/decimal-point outputs to the seven-segment mux.
interface sevenseg_display_sched_if;
  logic [15:0] score_bcd;
  logic        evt_req;
  logic [15:0] evt_bcd;
  logic        evt_busy;
  logic        scan_en;
  logic [3:0]  d3, d2, d1, d0;
  logic        dp3, dp2, dp1, dp0;

  modport master (
    output score_bcd, evt_req, evt_bcd,
    input  evt_busy, scan_en, d3, d2, d1, d0, dp3, dp2, dp1, dp0
  );

  modport slave (
    input  score_bcd, evt_req, evt_bcd,
    output evt_busy, scan_en, d3, d2, d1, d0, dp3, dp2, dp1, dp0
  );
endinterface

// File: rtl/sevenseg_display_sched_scan_prescaler.sv
// Free-running divider producing a registered 1-cycle tick every
// CLK_HZ/SCAN_HZ clocks; first tick lands DIV clocks after reset release.
module scan_prescaler
  import sevenseg_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int             DIV  = CLK_HZ / SCAN_HZ;
  localparam int             W    = cnt_width(DIV);
  localparam logic [W-1:0]   LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/sevenseg_display_sched.sv
// Display scheduler: live score by default, one-shot event messages held for
// HOLD_TICKS scan ticks. Define SEVENSEG_BLINK_EN to blink events.
module sevenseg_display_sched
  import sevenseg_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int HOLD_TICKS  = 1500,
  parameter int BLINK_TICKS = 250
) (
  input logic                    clk,
  input logic                    rst,
  sevenseg_display_sched_if.slave bus
);
  localparam int                  HOLD_W    = cnt_width(HOLD_TICKS);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  if (CLK_HZ / SCAN_HZ < 2 || HOLD_TICKS < 1 || BLINK_TICKS < 1) begin : g_bad_cfg
    $error("sevenseg_display_sched: invalid timing parameters");
  end

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [15:0]         capt, capt_nxt;
  logic                tick;
  logic                show_on;
  logic [15:0]         d_nxt;
  logic [3:0]          dp_nxt;
  logic                busy_nxt;

`ifdef SEVENSEG_BLINK_EN
  localparam int                 BLINK_W    = cnt_width(BLINK_TICKS);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  logic [BLINK_W-1:0] blink_cnt, blink_nxt;
  logic               phase_on, phase_nxt;
`endif

  // Leading-zero suppression; the units digit always stays visible.
  function automatic logic [15:0] blank_lz(input logic [15:0] s);
    logic z3, z32, z321;
    z3   = (s[15:12] == 4'd0);
    z32  = z3  && (s[11:8] == 4'd0);
    z321 = z32 && (s[7:4]  == 4'd0);
    return {z3   ? BLANK_DIGIT : s[15:12],
            z32  ? BLANK_DIGIT : s[11:8],
            z321 ? BLANK_DIGIT : s[7:4],
            s[3:0]};
  endfunction

  scan_prescaler #(
    .CLK_HZ (CLK_HZ),
    .SCAN_HZ(SCAN_HZ)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign bus.scan_en = tick;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    capt_nxt  = capt;
    show_on   = 1'b1;
    // A new request always wins, even against a simultaneous expiry.
    if (bus.evt_req) begin
      state_nxt = SHOW_EVENT;
      hold_nxt  = HOLD_LAST;
      capt_nxt  = bus.evt_bcd;
    end else if (state == SHOW_EVENT && tick) begin
      if (hold_cnt == '0) state_nxt = SHOW_SCORE;
      else                hold_nxt  = hold_cnt - 1'b1;
    end
`ifdef SEVENSEG_BLINK_EN
    blink_nxt = blink_cnt;
    phase_nxt = phase_on;
    if (bus.evt_req) begin
      blink_nxt = BLINK_LAST;
      phase_nxt = 1'b1;
    end else if (state == SHOW_EVENT && tick) begin
      if (blink_cnt == '0) begin
        blink_nxt = BLINK_LAST;
        phase_nxt = ~phase_on;
      end else begin
        blink_nxt = blink_cnt - 1'b1;
      end
    end
    show_on = phase_nxt;
`endif
    if (state_nxt == SHOW_EVENT) begin
      d_nxt    = show_on ? capt_nxt : {4{BLANK_DIGIT}};
      dp_nxt   = {DP_OFF, DP_OFF, DP_OFF, show_on ? ~DP_OFF : DP_OFF};
      busy_nxt = 1'b1;
    end else begin
      d_nxt    = blank_lz(bus.score_bcd);
      dp_nxt   = {4{DP_OFF}};
      busy_nxt = 1'b0;
    end
  end

  // Output register stage: display follows the next owner in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SHOW_SCORE;
      hold_cnt     <= '0;
      capt         <= {4{BLANK_DIGIT}};
      bus.d3       <= BLANK_DIGIT;
      bus.d2       <= BLANK_DIGIT;
      bus.d1       <= BLANK_DIGIT;
      bus.d0       <= BLANK_DIGIT;
      bus.dp3      <= DP_OFF;
      bus.dp2      <= DP_OFF;
      bus.dp1      <= DP_OFF;
      bus.dp0      <= DP_OFF;
      bus.evt_busy <= 1'b0;
`ifdef SEVENSEG_BLINK_EN
      blink_cnt    <= '0;
      phase_on     <= 1'b1;
`endif
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_nxt;
      capt         <= capt_nxt;
      bus.d3       <= d_nxt[15:12];
      bus.d2       <= d_nxt[11:8];
      bus.d1       <= d_nxt[7:4];
      bus.d0       <= d_nxt[3:0];
      bus.dp3      <= dp_nxt[3];
      bus.dp2      <= dp_nxt[2];
      bus.dp1      <= dp_nxt[1];
      bus.dp0      <= dp_nxt[0];
      bus.evt_busy <= busy_nxt;
`ifdef SEVENSEG_BLINK_EN
      blink_cnt    <= blink_nxt;
      phase_on     <= phase_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_sevenseg_display_sched.sv
// Bench for sevenseg_display_sched: directed scenarios plus randomized traffic
// against a tick-counting reference model of the display owner.
module tb_sevenseg_display_sched;
  localparam int CLK_HZ = 1000;
  localparam int SCAN_HZ = 100;
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int HOLD = 4;
  localparam int BLINK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sevenseg_display_sched_if bus();

  sevenseg_display_sched #(
    .CLK_HZ     (CLK_HZ),
    .SCAN_HZ    (SCAN_HZ),
    .HOLD_TICKS (HOLD),
    .BLINK_TICKS(BLINK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: clocks since reset, event ownership and ticks consumed.
  int          m_cyc = 0;
  bit          m_ev = 1'b0;
  int          m_seen = 0;
  logic [15:0] m_cap = 16'hFFFF;
  logic [21:0] exp_vec = {16'hFFFF, 4'hF, 2'b00};

  function automatic logic [15:0] ref_blank(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 3; i >= 1; i--) begin
      if (s[i*4 +: 4] != 4'd0) break;
      r[i*4 +: 4] = 4'hF;
    end
    return r;
  endfunction

  function automatic logic [21:0] obs();
    return {bus.d3, bus.d2, bus.d1, bus.d0, bus.dp3, bus.dp2, bus.dp1, bus.dp0,
            bus.evt_busy, bus.scan_en};
  endfunction

  always @(posedge clk) begin
    logic tick_now;
    logic on;
    if (rst) begin
      m_cyc = 0;
      m_ev = 1'b0;
      m_seen = 0;
      exp_vec = {16'hFFFF, 4'hF, 2'b00};
    end else begin
      tick_now = exp_vec[0];
      if (bus.evt_req) begin
        m_ev = 1'b1;
        m_cap = bus.evt_bcd;
        m_seen = 0;
      end else if (m_ev && tick_now) begin
        m_seen++;
        if (m_seen == HOLD) m_ev = 1'b0;
      end
      m_cyc++;
      exp_vec[0] = (m_cyc % DIV == 0);
      if (m_ev) begin
        on = 1'b1;
`ifdef SEVENSEG_BLINK_EN
        on = ((m_seen / BLINK) % 2 == 0);
`endif
        exp_vec[21:1] = on ? {m_cap, 4'b1110, 1'b1} : {16'hFFFF, 4'b1111, 1'b1};
      end else begin
        exp_vec[21:1] = {ref_blank(bus.score_bcd), 4'hF, 1'b0};
      end
    end
  end

  // Runs from a negedge while the event is busy; counts scan pulses seen,
  // optionally stopping on the stop_ticks-th pulse. Reports model mismatches.
  task automatic watch(input int stop_ticks, output int ticks, output int mism, output bit tmo);
    int c;
    ticks = 0;
    mism = 0;
    tmo = 1'b0;
    c = 0;
    while (1) begin
      if (c >= 300) begin tmo = 1'b1; break; end
      if (bus.evt_busy !== 1'b1) break;
      if (bus.scan_en === 1'b1) begin
        ticks++;
        if (ticks == stop_ticks) break;
      end
      @(negedge clk);
      if (obs() !== exp_vec) mism++;
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.score_bcd = 16'h1234;
    repeat (3) @(negedge clk);
    checks++;
    if (obs() !== {16'hFFFF, 4'hF, 2'b00}) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", obs(), {16'hFFFF, 4'hF, 2'b00});
    end
    rst = 1'b0;
    for (int i = 1; i <= 35; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.scan_en !== (i % DIV == 0)) begin
        errors++;
        $display("FAIL scan_pulse clk=%0d got=%b exp=%b", i, bus.scan_en, (i % DIV == 0));
      end
      checks++;
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL model_reset clk=%0d got=%h exp=%h", i, obs(), exp_vec);
      end
    end
  endtask

  task automatic test_score();
    logic [15:0] vals [4];
    logic [15:0] exps [4];
    logic [15:0] s;
    vals = '{16'h0042, 16'h0000, 16'h1005, 16'h00A7};
    exps = '{16'hFF42, 16'hFFF0, 16'h1005, 16'hFFA7};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.score_bcd = vals[i];
      @(negedge clk);
      checks++;
      if ({bus.d3, bus.d2, bus.d1, bus.d0} !== exps[i]) begin
        errors++;
        $display("FAIL score_blank in=%h got=%h exp=%h", vals[i], {bus.d3, bus.d2, bus.d1, bus.d0}, exps[i]);
      end
      checks++;
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL model_score in=%h got=%h exp=%h", vals[i], obs(), exp_vec);
      end
    end
    for (int i = 0; i < 20; i++) begin
      for (int n = 0; n < 4; n++)
        s[n*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.score_bcd = s;
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL model_score_rand in=%h got=%h exp=%h", s, obs(), exp_vec);
      end
    end
  endtask

  task automatic test_event();
    int ticks, mism;
    bit tmo;
    @(negedge clk);
    bus.score_bcd = 16'h0042;
    bus.evt_bcd = 16'h0300;
    bus.evt_req = 1'b1;
    @(negedge clk);
    bus.evt_req = 1'b0;
    bus.score_bcd = 16'h0777;
    checks++;
    if ({bus.d3, bus.d2, bus.d1, bus.d0, bus.dp3, bus.dp2, bus.dp1, bus.dp0, bus.evt_busy}
        !== {16'h0300, 4'b1110, 1'b1}) begin
      errors++;
      $display("FAIL event_show got=%h exp=%h", obs(), {16'h0300, 4'b1110, 1'b1, 1'bx});
    end
    watch(0, ticks, mism, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL event_timeout got=busy exp=idle"); end
    checks++;
    if (ticks != HOLD) begin errors++; $display("FAIL event_hold got=%0d exp=%0d", ticks, HOLD); end
    checks++;
    if (mism != 0) begin errors++; $display("FAIL model_event got=%0d exp=0 mismatching cycles", mism); end
    checks++;
    if ({bus.d3, bus.d2, bus.d1, bus.d0, bus.dp3, bus.dp2, bus.dp1, bus.dp0, bus.evt_busy}
        !== {16'hF777, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL event_return got=%h exp=%h", obs(), {16'hF777, 4'hF, 1'b0, 1'bx});
    end
  endtask

  task automatic test_back_to_back();
    int ticks, mism;
    bit tmo;
    @(negedge clk);
    bus.evt_bcd = 16'h0300;
    bus.evt_req = 1'b1;
    @(negedge clk);
    bus.evt_req = 1'b0;
    watch(2, ticks, mism, tmo);
    checks++;
    if (tmo || ticks != 2 || mism != 0) begin
      errors++;
      $display("FAIL rereq_first got=ticks%0d/mism%0d/tmo%0d exp=ticks2/mism0/tmo0", ticks, mism, tmo);
    end
    bus.evt_bcd = 16'h0200;
    bus.evt_req = 1'b1;
    @(negedge clk);
    bus.evt_req = 1'b0;
    checks++;
    if ({bus.d3, bus.d2, bus.d1, bus.d0, bus.evt_busy} !== {16'h0200, 1'b1}) begin
      errors++;
      $display("FAIL rereq_show got=%h exp=%h", {bus.d3, bus.d2, bus.d1, bus.d0, bus.evt_busy}, {16'h0200, 1'b1});
    end
    watch(0, ticks, mism, tmo);
    checks++;
    if (tmo || ticks != HOLD || mism != 0) begin
      errors++;
      $display("FAIL rereq_hold got=ticks%0d/mism%0d/tmo%0d exp=ticks%0d/mism0/tmo0", ticks, mism, tmo, HOLD);
    end
    // Request landing on the expiry tick keeps the event alive.
    @(negedge clk);
    bus.evt_bcd = 16'h0101;
    bus.evt_req = 1'b1;
    @(negedge clk);
    bus.evt_req = 1'b0;
    watch(HOLD, ticks, mism, tmo);
    checks++;
    if (tmo || ticks != HOLD || mism != 0) begin
      errors++;
      $display("FAIL expiry_reach got=ticks%0d/mism%0d/tmo%0d exp=ticks%0d/mism0/tmo0", ticks, mism, tmo, HOLD);
    end
    bus.evt_bcd = 16'h0909;
    bus.evt_req = 1'b1;
    @(negedge clk);
    bus.evt_req = 1'b0;
    checks++;
    if ({bus.d3, bus.d2, bus.d1, bus.d0, bus.dp0, bus.evt_busy} !== {16'h0909, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL expiry_collide got=%h exp=%h", {bus.d3, bus.d2, bus.d1, bus.d0, bus.dp0, bus.evt_busy}, {16'h0909, 1'b0, 1'b1});
    end
    watch(0, ticks, mism, tmo);
    checks++;
    if (tmo || ticks != HOLD || mism != 0) begin
      errors++;
      $display("FAIL expiry_hold got=ticks%0d/mism%0d/tmo%0d exp=ticks%0d/mism0/tmo0", ticks, mism, tmo, HOLD);
    end
  endtask

  task automatic test_reset_mid();
    int ticks, mism;
    bit tmo;
    @(negedge clk);
    bus.score_bcd = 16'h0050;
    bus.evt_bcd = 16'h4321;
    bus.evt_req = 1'b1;
    @(negedge clk);
    bus.evt_req = 1'b0;
    watch(1, ticks, mism, tmo);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== {16'hFFFF, 4'hF, 2'b00}) begin
      errors++;
      $display("FAIL midreset_state got=%h exp=%h", obs(), {16'hFFFF, 4'hF, 2'b00});
    end
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus.scan_en, bus.evt_busy} !== {(i == DIV), 1'b0}) begin
        errors++;
        $display("FAIL midreset_after clk=%0d got=%b%b exp=%b0", i, bus.scan_en, bus.evt_busy, (i == DIV));
      end
    end
    checks++;
    if ({bus.d3, bus.d2, bus.d1, bus.d0, bus.dp0} !== {16'hFF50, 1'b1}) begin
      errors++;
      $display("FAIL midreset_score got=%h exp=%h", {bus.d3, bus.d2, bus.d1, bus.d0, bus.dp0}, {16'hFF50, 1'b1});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL model_rand cyc=%0d got=%h exp=%h", i, obs(), exp_vec);
      end
      bus.evt_req = ($urandom_range(0, 39) == 0);
      bus.evt_bcd = 16'($urandom());
      if ($urandom_range(0, 19) == 0) bus.score_bcd = 16'($urandom_range(0, 16'h0FFF));
      rst = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    bus.evt_req = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    bus.score_bcd = 16'h0000;
    bus.evt_req = 1'b0;
    bus.evt_bcd = 16'h0000;
    test_reset();
    test_score();
    test_event();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
